// File: rtl/hram_arb_pkg.sv
// Shared types and helpers for the two-master HyperRAM Avalon-MM burst arbiter.
package hram_arb_pkg;

    localparam int DEFAULT_ADDR_W  = 32;
    localparam int DEFAULT_DATA_W  = 16;
    localparam int DEFAULT_BURST_W = 11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_CMD   = 2'd2,
        RD_DATA  = 2'd3
    } arb_state_e;

    // Avalon burstcount 0 means a single beat.
    function automatic logic [31:0] norm_burst(input logic [31:0] bc);
        return (bc == 32'd0) ? 32'd1 : bc;
    endfunction

endpackage

// File: rtl/hram_arb_rr_pick.sv
// Two-input winner picker: round-robin on last_grant, or fixed m0 priority
// when HRAM_ARB_FIXED_PRIO_EN is defined.
module hram_arb_rr_pick
    import hram_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       grant_o
);

`ifdef HRAM_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant_i;
    assign grant_o           = ~req_i[0] & req_i[1];
`else
    // On contention the master that did not win last time goes next.
    assign grant_o = (req_i == 2'b11) ? ~last_grant_i : req_i[1];
`endif

endmodule

// File: rtl/hram_avs_arbiter.sv
// Whole-burst arbiter sharing the HyperRAM converter slave between m0 and m1.
// Optional fixed m0 priority via HRAM_ARB_FIXED_PRIO_EN (round-robin otherwise).
module hram_avs_arbiter
    import hram_arb_pkg::*;
#(
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int BURST_W = DEFAULT_BURST_W
) (
    input  logic               clk_clk,
    input  logic               reset_reset_n,

    input  logic [ADDR_W-1:0]  m0_address,
    input  logic               m0_read,
    input  logic               m0_write,
    input  logic [DATA_W-1:0]  m0_writedata,
    input  logic [BURST_W-1:0] m0_burstcount,
    output logic [DATA_W-1:0]  m0_readdata,
    output logic               m0_readdatavalid,
    output logic               m0_waitrequest,

    input  logic [ADDR_W-1:0]  m1_address,
    input  logic               m1_read,
    input  logic               m1_write,
    input  logic [DATA_W-1:0]  m1_writedata,
    input  logic [BURST_W-1:0] m1_burstcount,
    output logic [DATA_W-1:0]  m1_readdata,
    output logic               m1_readdatavalid,
    output logic               m1_waitrequest,

    output logic [ADDR_W-1:0]  avm_address,
    output logic               avm_read,
    output logic               avm_write,
    output logic [DATA_W-1:0]  avm_writedata,
    output logic [BURST_W-1:0] avm_burstcount,
    input  logic [DATA_W-1:0]  avm_readdata,
    input  logic               avm_readdatavalid,
    input  logic               avm_waitrequest
);

    arb_state_e         state_q, state_d;
    logic               owner_q, owner_d;
    logic               last_grant_q, last_grant_d;
    logic [BURST_W-1:0] beats_q, beats_d;

    logic [1:0]         req;
    logic               winner;
    logic               win_write;
    logic [BURST_W-1:0] win_bc;

    logic               own_read, own_write;
    logic               own_wait, own_rdv;
    logic               beat_last;
    logic               cmd_acc;

    assign req       = {m1_read | m1_write, m0_read | m0_write};
    assign win_write = winner ? m1_write : m0_write;
    assign win_bc    = winner ? m1_burstcount : m0_burstcount;

    hram_arb_rr_pick u_pick (
        .req_i        (req),
        .last_grant_i (last_grant_q),
        .grant_o      (winner)
    );

    assign own_read       = owner_q ? m1_read : m0_read;
    assign own_write      = owner_q ? m1_write : m0_write;
    assign avm_address    = owner_q ? m1_address : m0_address;
    assign avm_writedata  = owner_q ? m1_writedata : m0_writedata;
    assign avm_burstcount = owner_q ? m1_burstcount : m0_burstcount;

    assign beat_last = (beats_q == BURST_W'(1));
    assign cmd_acc   = own_read & ~avm_waitrequest;

    // NOTE: non-blocking (<=) so every flop samples the pre-edge values of the others.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            beats_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            beats_q      <= beats_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        beats_d      = beats_q;
        avm_read     = 1'b0;
        avm_write    = 1'b0;
        own_wait     = 1'b1;
        own_rdv      = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    owner_d = winner;
                    beats_d = BURST_W'(norm_burst(32'(win_bc)));
                    state_d = win_write ? WR_BURST : RD_CMD;
                end
            end

            WR_BURST: begin
                avm_write = own_write;
                own_wait  = avm_waitrequest;
                if (own_write && !avm_waitrequest) begin
                    if (beat_last) begin
                        state_d      = IDLE;
                        last_grant_d = owner_q;
                    end else begin
                        beats_d = beats_q - BURST_W'(1);
                    end
                end
            end

            RD_CMD: begin
                avm_read = own_read;
                own_wait = avm_waitrequest;
                own_rdv  = avm_readdatavalid;
                // An early beat is counted, but the counter never drops below 1 here.
                if (avm_readdatavalid && !beat_last) begin
                    beats_d = beats_q - BURST_W'(1);
                end
                if (cmd_acc) begin
                    if (avm_readdatavalid && beat_last) begin
                        state_d      = IDLE;
                        last_grant_d = owner_q;
                    end else begin
                        state_d = RD_DATA;
                    end
                end
            end

            RD_DATA: begin
                own_rdv = avm_readdatavalid;
                if (avm_readdatavalid) begin
                    if (beat_last) begin
                        state_d      = IDLE;
                        last_grant_d = owner_q;
                    end else begin
                        beats_d = beats_q - BURST_W'(1);
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign m0_waitrequest   = owner_q ? 1'b1 : own_wait;
    assign m1_waitrequest   = owner_q ? own_wait : 1'b1;
    assign m0_readdatavalid = ~owner_q & own_rdv;
    assign m1_readdatavalid = owner_q & own_rdv;
    assign m0_readdata      = avm_readdata;
    assign m1_readdata      = avm_readdata;

endmodule

// File: tb/tb_hram_avs_arbiter.sv
// Self-checking bench for hram_avs_arbiter: directed scenarios plus random traffic
// against a burst-level reference model of the arbitration rules.
module tb_hram_avs_arbiter;

    localparam int AW = 32;
    localparam int DW = 16;
    localparam int BW = 11;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0] m_addr  [2];
    logic          m_read  [2];
    logic          m_write [2];
    logic [DW-1:0] m_wdata [2];
    logic [BW-1:0] m_bc    [2];
    logic [DW-1:0] m_rdata [2];
    logic          m_rdv   [2];
    logic          m_wait  [2];

    logic [AW-1:0] avm_address;
    logic          avm_read, avm_write;
    logic [DW-1:0] avm_writedata;
    logic [BW-1:0] avm_burstcount;
    logic [DW-1:0] avm_readdata      = '0;
    logic          avm_readdatavalid = 1'b0;
    logic          avm_waitrequest   = 1'b0;

    hram_avs_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_W(BW)) dut (
        .clk_clk           (clk),
        .reset_reset_n     (rst_n),
        .m0_address        (m_addr[0]),
        .m0_read           (m_read[0]),
        .m0_write          (m_write[0]),
        .m0_writedata      (m_wdata[0]),
        .m0_burstcount     (m_bc[0]),
        .m0_readdata       (m_rdata[0]),
        .m0_readdatavalid  (m_rdv[0]),
        .m0_waitrequest    (m_wait[0]),
        .m1_address        (m_addr[1]),
        .m1_read           (m_read[1]),
        .m1_write          (m_write[1]),
        .m1_writedata      (m_wdata[1]),
        .m1_burstcount     (m_bc[1]),
        .m1_readdata       (m_rdata[1]),
        .m1_readdatavalid  (m_rdv[1]),
        .m1_waitrequest    (m_wait[1]),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_burstcount    (avm_burstcount),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .avm_waitrequest   (avm_waitrequest)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Burst-level reference: who owns the slave, what kind of burst, beats left.
    bit md_busy = 1'b0;
    bit md_wr   = 1'b0;
    bit md_cmd  = 1'b0;
    int md_own  = 0;
    int md_left = 0;
    int md_last = 1;

    int wr_beats, m1_wait_low, m0_stalls, first_rdv;
    int rdv_cnt [2];
    int beat_log [$];

    task automatic clear_mon();
        wr_beats    = 0;
        m1_wait_low = 0;
        m0_stalls   = 0;
        first_rdv   = -1;
        rdv_cnt[0]  = 0;
        rdv_cnt[1]  = 0;
        beat_log.delete();
    endtask

    always @(negedge clk) begin : cmp
        logic e_wait [2];
        logic e_rdv  [2];
        logic e_rd, e_wr;
        bit   r0, r1;
        int   w;

        if (!rst_n) begin
            md_busy = 1'b0;
            md_wr   = 1'b0;
            md_cmd  = 1'b0;
            md_own  = 0;
            md_left = 0;
            md_last = 1;
        end

        for (int i = 0; i < 2; i++) begin
            e_wait[i] = 1'b1;
            e_rdv[i]  = 1'b0;
        end
        e_rd = 1'b0;
        e_wr = 1'b0;
        if (md_busy) begin
            e_wait[md_own] = (md_wr || !md_cmd) ? avm_waitrequest : 1'b1;
            e_rdv[md_own]  = md_wr ? 1'b0 : avm_readdatavalid;
            e_rd           = (!md_wr && !md_cmd) ? m_read[md_own] : 1'b0;
            e_wr           = md_wr ? m_write[md_own] : 1'b0;
            check("avm_address", avm_address, m_addr[md_own]);
            check("avm_writedata", avm_writedata, m_wdata[md_own]);
            check("avm_burstcount", avm_burstcount, m_bc[md_own]);
        end
        for (int i = 0; i < 2; i++) begin
            check($sformatf("m%0d_waitrequest", i), m_wait[i], e_wait[i]);
            check($sformatf("m%0d_readdatavalid", i), m_rdv[i], e_rdv[i]);
            check($sformatf("m%0d_readdata", i), m_rdata[i], avm_readdata);
        end
        check("avm_read", avm_read, e_rd);
        check("avm_write", avm_write, e_wr);

        if (avm_write && !avm_waitrequest) wr_beats++;
        if (!m_wait[1]) m1_wait_low++;
        if (m_write[0] && m_wait[0]) m0_stalls++;
        for (int i = 0; i < 2; i++) begin
            if (m_rdv[i]) begin
                rdv_cnt[i]++;
                if (first_rdv < 0) first_rdv = i;
            end
            if (m_write[i] && !m_wait[i]) beat_log.push_back(i);
        end

        if (rst_n) begin
            if (!md_busy) begin
                r0 = m_read[0] | m_write[0];
                r1 = m_read[1] | m_write[1];
                if (r0 || r1) begin
`ifdef HRAM_ARB_FIXED_PRIO_EN
                    w = r0 ? 0 : 1;
`else
                    w = (r0 && r1) ? (md_last == 0 ? 1 : 0) : (r1 ? 1 : 0);
`endif
                    md_busy = 1'b1;
                    md_own  = w;
                    md_wr   = m_write[w];
                    md_cmd  = 1'b0;
                    md_left = (m_bc[w] == 0) ? 1 : int'(m_bc[w]);
                end
            end else if (md_wr) begin
                if (m_write[md_own] && !avm_waitrequest) begin
                    md_left--;
                    if (md_left == 0) begin
                        md_busy = 1'b0;
                        md_last = md_own;
                    end
                end
            end else begin
                if (avm_readdatavalid) md_left--;
                if (!md_cmd && m_read[md_own] && !avm_waitrequest) md_cmd = 1'b1;
                if (md_cmd && md_left <= 0) begin
                    md_busy = 1'b0;
                    md_last = md_own;
                end
            end
        end
    end

    // Converter stand-in: random stalls, returns the beats of each accepted read.
    int  wait_pct = 0;
    int  rdv_pct  = 100;
    bit  stray    = 1'b0;
    int  wq [$];
    int  pend     = 0;
    logic acc_rd_s = 1'b0;
    logic rdv_s    = 1'b0;
    int   bc_s     = 0;

    always @(negedge clk) begin
        acc_rd_s = avm_read && !avm_waitrequest;
        rdv_s    = avm_readdatavalid;
        bc_s     = int'(avm_burstcount);
    end

    always @(posedge clk) begin
        #2;
        if (!rst_n) begin
            pend = 0;
        end else begin
            if (acc_rd_s) pend += (bc_s == 0) ? 1 : bc_s;
            if (rdv_s && pend > 0) pend--;
        end
        if (wq.size() > 0) avm_waitrequest = (wq.pop_front() != 0);
        else               avm_waitrequest = ($urandom_range(99) < wait_pct);
        if (stray) begin
            avm_readdatavalid = 1'b1;
            stray = 1'b0;
        end else begin
            avm_readdatavalid = (pend > 0) && ($urandom_range(99) < rdv_pct);
        end
        avm_readdata = DW'($urandom);
    end

    task automatic do_write(input int m, input int bc, input int gap_pct, input bit keep);
        int n;
        int cnt;
        int guard;
        bit acc;
        n     = (bc == 0) ? 1 : bc;
        cnt   = 0;
        guard = 0;
        @(posedge clk); #1;
        m_read[m]  = 1'b0;
        m_write[m] = 1'b1;
        m_bc[m]    = BW'(bc);
        m_addr[m]  = AW'($urandom);
        m_wdata[m] = DW'($urandom);
        while (cnt < n) begin
            @(negedge clk);
            acc = m_write[m] && !m_wait[m];
            @(posedge clk); #1;
            guard++;
            if (acc) begin
                cnt++;
                m_wdata[m] = DW'($urandom);
            end
            if (guard > 500) begin
                check($sformatf("m%0d_write_timeout", m), cnt, n);
                break;
            end
            if (cnt < n && gap_pct > 0) m_write[m] = ($urandom_range(99) >= gap_pct);
            else if (cnt < n)           m_write[m] = 1'b1;
        end
        if (!keep) m_write[m] = 1'b0;
    endtask

    task automatic do_read(input int m, input int bc);
        int n;
        int cnt;
        int guard;
        bit acc;
        n     = (bc == 0) ? 1 : bc;
        cnt   = 0;
        guard = 0;
        acc   = 1'b0;
        @(posedge clk); #1;
        m_write[m] = 1'b0;
        m_read[m]  = 1'b1;
        m_bc[m]    = BW'(bc);
        m_addr[m]  = AW'($urandom);
        while (!acc && guard <= 500) begin
            @(negedge clk);
            acc = m_read[m] && !m_wait[m];
            @(posedge clk); #1;
            guard++;
        end
        m_read[m] = 1'b0;
        while (cnt < n && guard <= 500) begin
            @(negedge clk);
            if (m_rdv[m]) cnt++;
            guard++;
        end
        if (guard > 500) check($sformatf("m%0d_read_timeout", m), cnt, n);
        @(posedge clk); #1;
    endtask

    task automatic rand_master(input int m, input int n_tx);
        int bc;
        repeat (n_tx) begin
            repeat ($urandom_range(3)) @(posedge clk);
            bc = $urandom_range(6);
            if ($urandom_range(1) == 1) do_write(m, bc, 25, 1'b0);
            else                        do_read(m, bc);
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_m1;
        for (int i = 0; i < 2; i++) begin
            m_addr[i]  = '0;
            m_read[i]  = 1'b0;
            m_write[i] = 1'b0;
            m_wdata[i] = '0;
            m_bc[i]    = '0;
        end
        clear_mon();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle after reset.
        @(negedge clk);
        check("rst_m0_waitrequest", m_wait[0], 1'b1);
        check("rst_m1_waitrequest", m_wait[1], 1'b1);
        check("rst_avm_read", avm_read, 1'b0);
        check("rst_avm_write", avm_write, 1'b0);
        check("rst_m0_rdv", m_rdv[0], 1'b0);
        check("rst_m1_rdv", m_rdv[1], 1'b0);

        // m0 write burst of 4 with a ready converter.
        clear_mon();
        do_write(0, 4, 0, 1'b0);
        @(negedge clk);
        check("wr4_beats", wr_beats, 4);
        check("wr4_m1_never_granted", m1_wait_low, 0);
        check("wr4_back_idle_m0_wait", m_wait[0], 1'b1);
        check("wr4_model_last_grant", md_last, 0);

        // Simultaneous reads of 2: m0 first, then m1, beats routed per owner.
        pulse_reset();
        clear_mon();
        fork
            do_read(0, 2);
            do_read(1, 2);
        join
        check("rd2_m0_beats", rdv_cnt[0], 2);
        check("rd2_m1_beats", rdv_cnt[1], 2);
        check("rd2_m0_first", first_rdv, 0);

        // Read with burstcount 0 is a single beat.
        clear_mon();
        do_read(1, 0);
        @(negedge clk);
        check("rd0_m1_beats", rdv_cnt[1], 1);
        check("rd0_m0_beats", rdv_cnt[0], 0);
        check("rd0_model_idle", md_busy, 1'b0);

        // Write of 3 with converter stalls 1,0,1,0,0 (leading entry covers the arbitration cycle).
        @(posedge clk); #3;
        wq = '{1, 1, 0, 1, 0, 0};
        clear_mon();
        do_write(0, 3, 0, 1'b0);
        check("wr3_beats", wr_beats, 3);
        check("wr3_m0_stall_cycles", m0_stalls, 3);

        // Both masters hold write requests continuously.
        pulse_reset();
        clear_mon();
        fork
            begin
                repeat (3) do_write(0, 2, 0, 1'b1);
                m_write[0] = 1'b0;
            end
            do_write(1, 2, 0, 1'b0);
        join
        first_m1 = -1;
        foreach (beat_log[k]) if (first_m1 < 0 && beat_log[k] == 1) first_m1 = k;
        check("prio_total_beats", beat_log.size(), 8);
`ifdef HRAM_ARB_FIXED_PRIO_EN
        check("prio_first_m1_beat", first_m1, 6);
`else
        check("prio_first_m1_beat", first_m1, 2);
`endif

        // Reset in the middle of a read data phase, then a stray beat.
        rdv_pct = 0;
        @(posedge clk); #1;
        m_read[0] = 1'b1;
        m_bc[0]   = BW'(4);
        begin
            bit acc = 1'b0;
            int guard = 0;
            while (!acc && guard < 20) begin
                @(negedge clk);
                acc = m_read[0] && !m_wait[0];
                @(posedge clk); #1;
                guard++;
            end
            check("rst_mid_cmd_accepted", acc, 1'b1);
        end
        m_read[0] = 1'b0;
        @(posedge clk); #4;
        rst_n = 1'b0;
        #1;
        check("rst_mid_m0_waitrequest", m_wait[0], 1'b1);
        check("rst_mid_m1_waitrequest", m_wait[1], 1'b1);
        check("rst_mid_avm_read", avm_read, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        stray = 1'b1;
        @(negedge clk);
        check("stray_m0_rdv", m_rdv[0], 1'b0);
        check("stray_m1_rdv", m_rdv[1], 1'b0);
        rdv_pct = 100;
        do_write(1, 1, 0, 1'b0);

        // Random traffic from both masters with a stalling converter.
        wait_pct = 30;
        rdv_pct  = 60;
        fork
            rand_master(0, 40);
            rand_master(1, 40);
        join
        repeat (5) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
